// File: rtl/iis_pkg.sv
// Shared definitions for the I2S receive path: sample width, channel codes,
// receiver FSM states and the bit-counter width helper.
package iis_pkg;

    localparam int IIS_DATA_W = 24;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } chan_e;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SHIFT,
        HOLD
    } state_e;

    // Counter must be able to hold the value DATA_W itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int IIS_CNT_W = cnt_width(IIS_DATA_W);

endpackage

// File: rtl/iis_edge_sync.sv
// Single-bit synchroniser into the system clock domain, plus a history flop
// that yields one-cycle rise/fall strobes on the synchronised value.
module iis_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign q    = sync[SYNC_STAGES-1];
    assign rise = q & ~hist;
    assign fall = ~q & hist;

endmodule

// File: rtl/iis_read_logic.sv
// I2S receiver: oversamples bclk/lrclk/sdata_i in the system clock domain and
// delivers one left/right sample pair per frame with a single-cycle valid.
module iis_read_logic
    import iis_pkg::*;
#(
    parameter int DATA_W      = IIS_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_100m,
    input  logic              rst,
    input  logic              en,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic              sdata_i,
    output logic [DATA_W-1:0] ldata,
    output logic [DATA_W-1:0] rdata,
    output logic              valid,
    output logic              frame_err
);

    localparam int              CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    // Index 0 = bclk, 1 = lrclk, 2 = sdata_i; equal depth keeps them aligned.
    logic [2:0] pins, sync_q, sync_rise, sync_fall;
    assign pins = {sdata_i, lrclk, bclk};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        iis_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk_100m),
            .rst  (rst),
            .d    (pins[i]),
            .q    (sync_q[i]),
            .rise (sync_rise[i]),
            .fall (sync_fall[i])
        );
    end

    logic unused_sync;
    assign unused_sync = ^{sync_q[0], sync_rise[2:1], sync_fall};

    logic bclk_rise, lrclk_s, sdata_s;
    assign bclk_rise = sync_rise[0];
    assign lrclk_s   = sync_q[1];
    assign sdata_s   = sync_q[2];

    state_e            state;
    chan_e             chan;
    logic              lr_prev;
    logic              have_left;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg, left_hold, word_next;
    logic              ch_change;

    assign ch_change = bclk_rise & (lrclk_s != lr_prev);
    assign word_next = {shreg[DATA_W-2:0], sdata_s};

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            chan      <= LEFT;
            lr_prev   <= 1'b0;
            have_left <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            left_hold <= '0;
            ldata     <= '0;
            rdata     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (bclk_rise)
                lr_prev <= lrclk_s;

            if (!en) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                shreg     <= '0;
                have_left <= 1'b0;
            end else if (bclk_rise) begin
                // The channel of the next word is the lrclk value at the edge.
                if (ch_change && state != ARM)
                    chan <= chan_e'(lrclk_s);

                case (state)
                    IDLE: if (ch_change) state <= ARM;
                    ARM: begin
                        shreg   <= {{(DATA_W-1){1'b0}}, sdata_s};
                        bit_cnt <= CNT_W'(1);
                        state   <= SHIFT;
                    end
                    SHIFT: begin
                        shreg   <= word_next;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_CNT) begin
                            // LSB can coincide with the next slot's lrclk edge.
                            if (chan == LEFT) begin
                                left_hold <= word_next;
                                have_left <= 1'b1;
                            end else begin
                                if (have_left) begin
                                    ldata <= left_hold;
                                    rdata <= word_next;
                                    valid <= 1'b1;
                                end
                                have_left <= 1'b0;
                            end
                            state <= ch_change ? ARM : HOLD;
                        end else if (ch_change) begin
                            frame_err <= 1'b1;
                            have_left <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= ARM;
                        end
                    end
                    HOLD: if (ch_change) state <= ARM;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iis_read_logic.sv
// Bench for iis_read_logic: drives I2S slot streams and checks captured pairs
// and frame errors against a slot-level model of the receive rules.
module tb_iis_read_logic;

    localparam int DW   = 24;
    localparam int SS   = 2;
    localparam int HALF = 5;

    logic          clk_100m = 1'b0;
    logic          rst = 1'b1, en = 1'b0, bclk = 1'b0, lrclk = 1'b0, sdata_i = 1'b0;
    logic [DW-1:0] ldata, rdata;
    logic          valid, frame_err;

    iis_read_logic #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk_100m (clk_100m),
        .rst      (rst),
        .en       (en),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata_i  (sdata_i),
        .ldata    (ldata),
        .rdata    (rdata),
        .valid    (valid),
        .frame_err(frame_err)
    );

    always #5 clk_100m = ~clk_100m;

    typedef struct {
        bit            ch;
        int            len;
        logic [DW-1:0] w;
    } slot_t;

    slot_t           slots[$];
    logic [2*DW-1:0] exp_q[$], got_q[$];
    int              exp_err;
    int              err_seen = 0, clash = 0, wide = 0, bad_lat = 0;
    int              cyc = 0, last_rise_cyc = 0;
    int              ntests = 0, nfail = 0;
    int              g0, e0, k0;
    logic            prev_valid = 1'b0;

    always @(posedge clk_100m) cyc <= cyc + 1;

    // Monitor: collect pairs, error pulses and timing anomalies.
    always @(negedge clk_100m) begin
        if (valid === 1'b1) begin
            got_q.push_back({ldata, rdata});
            if (cyc - last_rise_cyc < SS + 1 || cyc - last_rise_cyc > SS + 2) bad_lat++;
        end
        if (frame_err === 1'b1) err_seen++;
        if (valid === 1'b1 && frame_err === 1'b1) clash++;
        if (valid === 1'b1 && prev_valid === 1'b1) wide++;
        prev_valid = valid;
    end

    function automatic void add_slot(input bit ch, input int len, input logic [DW-1:0] w);
        slot_t s;
        s.ch = ch; s.len = len; s.w = w;
        slots.push_back(s);
    endfunction

    function automatic int rand_len();
        int r = int'($urandom_range(0, 5));
        if (r == 0) return int'($urandom_range(12, DW - 1));
        return (r == 1) ? 25 : (r == 2) ? 32 : (r == 3) ? 28 : DW;
    endfunction

    // Slot-level model: slot 0 is the sync slot and is never delivered.
    // A full left slot followed directly by a full right slot yields a pair;
    // any slot shorter than DW is an error and discards the held left word.
    function automatic void model();
        bit            hv = 1'b0;
        logic [DW-1:0] held = '0;
        exp_q.delete();
        exp_err = 0;
        for (int i = 1; i < slots.size(); i++) begin
            if (slots[i].len < DW) begin
                exp_err++;
                hv = 1'b0;
            end else if (slots[i].ch == 1'b0) begin
                held = slots[i].w;
                hv   = 1'b1;
            end else begin
                if (hv) exp_q.push_back({held, slots[i].w});
                hv = 1'b0;
            end
        end
    endfunction

    task automatic send_bit(input bit l, input bit d);
        @(negedge clk_100m);
        bclk = 1'b0; lrclk = l; sdata_i = d;
        repeat (HALF) @(negedge clk_100m);
        bclk = 1'b1;
        last_rise_cyc = cyc;
        repeat (HALF - 1) @(negedge clk_100m);
    endtask

    // Data lags lrclk by one bit: a slot's MSB is on its second bclk.
    task automatic send_stream(input bit trailing);
        bit lr_b[$], d_b[$];
        bit prev = 1'b0;
        foreach (slots[s])
            for (int k = 0; k < slots[s].len; k++) begin
                lr_b.push_back(slots[s].ch);
                d_b.push_back(k < DW ? slots[s].w[DW-1-k] : 1'($urandom));
            end
        for (int i = 0; i < lr_b.size(); i++) begin
            send_bit(lr_b[i], prev);
            prev = d_b[i];
        end
        if (trailing) send_bit(!lr_b[lr_b.size()-1], prev);
        repeat (8) @(negedge clk_100m);
    endtask

    task automatic start_stream();
        en = 1'b0;
        repeat (3) @(negedge clk_100m);
        en = 1'b1;
        slots.delete();
        add_slot(1'b1, DW, DW'($urandom));
        g0 = got_q.size(); e0 = err_seen; k0 = clash + wide + bad_lat;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_100m);
        ntests++;
        if ({ldata, rdata, valid, frame_err} !== '0) begin
            nfail++;
            $display("FAIL reset_hold: got l=%h r=%h v=%b e=%b, expected all zero", ldata, rdata, valid, frame_err);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk_100m);
        ntests++;
        if (ldata !== '0) begin nfail++; $display("FAIL reset_ldata: got %h expected 0", ldata); end
        ntests++;
        if (rdata !== '0) begin nfail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        ntests++;
        if (valid !== 1'b0 || frame_err !== 1'b0) begin
            nfail++; $display("FAIL reset_strobes: got v=%b e=%b expected 0 0", valid, frame_err);
        end
    endtask

    task automatic test_loopback();
        logic [2*DW-1:0] got;
        start_stream();
        repeat (3) begin add_slot(1'b0, DW, 24'hA5A5A5); add_slot(1'b1, DW, 24'h5A5A5A); end
        model();
        send_stream(1'b1);
        ntests++;
        if (got_q.size() - g0 != exp_q.size()) begin
            nfail++; $display("FAIL loopback_count: got %0d expected %0d", got_q.size() - g0, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
            ntests++;
            if (got !== exp_q[i]) begin nfail++; $display("FAIL loopback_pair%0d: got %h expected %h", i, got, exp_q[i]); end
        end
        ntests++;
        if (err_seen - e0 != exp_err || clash + wide + bad_lat != k0) begin
            nfail++; $display("FAIL loopback_err_timing: got errs %0d anomalies %0d expected %0d 0", err_seen - e0, clash + wide + bad_lat - k0, exp_err);
        end
    endtask

    task automatic test_boundary();
        logic [2*DW-1:0] got;
        start_stream();
        add_slot(1'b0, DW, 24'h800001); add_slot(1'b1, DW, 24'h7FFFFE);
        add_slot(1'b0, DW, 24'hFFFFFF); add_slot(1'b1, DW, 24'hFFFFFF);
        add_slot(1'b0, DW, 24'h000000); add_slot(1'b1, DW, 24'h000000);
        model();
        send_stream(1'b1);
        ntests++;
        if (got_q.size() - g0 != exp_q.size()) begin
            nfail++; $display("FAIL boundary_count: got %0d expected %0d", got_q.size() - g0, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
            ntests++;
            if (got !== exp_q[i]) begin nfail++; $display("FAIL boundary_pair%0d: got %h expected %h", i, got, exp_q[i]); end
        end
        ntests++;
        if (err_seen - e0 != exp_err || clash + wide + bad_lat != k0) begin
            nfail++; $display("FAIL boundary_err_timing: got errs %0d anomalies %0d expected %0d 0", err_seen - e0, clash + wide + bad_lat - k0, exp_err);
        end
    endtask

    task automatic test_slot32();
        logic [2*DW-1:0] got;
        start_stream();
        repeat (2) begin add_slot(1'b0, 32, 24'h123456); add_slot(1'b1, 32, 24'hABCDEF); end
        model();
        send_stream(1'b1);
        ntests++;
        if (got_q.size() - g0 != exp_q.size()) begin
            nfail++; $display("FAIL slot32_count: got %0d expected %0d", got_q.size() - g0, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
            ntests++;
            if (got !== exp_q[i]) begin nfail++; $display("FAIL slot32_pair%0d: got %h expected %h", i, got, exp_q[i]); end
        end
        ntests++;
        if (err_seen - e0 != exp_err || clash + wide + bad_lat != k0) begin
            nfail++; $display("FAIL slot32_err_timing: got errs %0d anomalies %0d expected %0d 0", err_seen - e0, clash + wide + bad_lat - k0, exp_err);
        end
    endtask

    task automatic test_short_slot();
        logic [2*DW-1:0] got;
        start_stream();
        add_slot(1'b0, 20, 24'h13579B); add_slot(1'b1, DW, 24'h2468AC);
        add_slot(1'b0, DW, 24'hC0FFEE); add_slot(1'b1, DW, 24'h0BADF0);
        model();
        send_stream(1'b1);
        ntests++;
        if (got_q.size() - g0 != exp_q.size()) begin
            nfail++; $display("FAIL short_count: got %0d expected %0d", got_q.size() - g0, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
            ntests++;
            if (got !== exp_q[i]) begin nfail++; $display("FAIL short_pair%0d: got %h expected %h", i, got, exp_q[i]); end
        end
        ntests++;
        if (err_seen - e0 != exp_err) begin
            nfail++; $display("FAIL short_frame_err: got %0d expected %0d", err_seen - e0, exp_err);
        end
        ntests++;
        if (clash + wide + bad_lat != k0) begin
            nfail++; $display("FAIL short_timing: got %0d anomalies expected 0", clash + wide + bad_lat - k0);
        end
    endtask

    task automatic test_random();
        logic [2*DW-1:0] got;
        start_stream();
        repeat (8) begin
            add_slot(1'b0, rand_len(), DW'($urandom));
            add_slot(1'b1, rand_len(), DW'($urandom));
        end
        model();
        send_stream(1'b1);
        ntests++;
        if (got_q.size() - g0 != exp_q.size()) begin
            nfail++; $display("FAIL random_count: got %0d expected %0d", got_q.size() - g0, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
            ntests++;
            if (got !== exp_q[i]) begin nfail++; $display("FAIL random_pair%0d: got %h expected %h", i, got, exp_q[i]); end
        end
        ntests++;
        if (err_seen - e0 != exp_err || clash + wide + bad_lat != k0) begin
            nfail++; $display("FAIL random_err_timing: got errs %0d anomalies %0d expected %0d 0", err_seen - e0, clash + wide + bad_lat - k0, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0]   l2, r2;
        logic [2*DW-1:0] got;
        start_stream();
        add_slot(1'b0, DW, DW'($urandom));
        add_slot(1'b1, 12, DW'($urandom));
        send_stream(1'b0);
        @(negedge clk_100m); bclk = 1'b0;
        repeat (3) @(negedge clk_100m);
        rst = 1'b1;
        repeat (3) @(negedge clk_100m);
        rst = 1'b0;
        repeat (4) @(negedge clk_100m);
        ntests++;
        if (ldata !== '0 || rdata !== '0 || got_q.size() != g0) begin
            nfail++; $display("FAIL rstmid_clear: got l=%h r=%h pairs %0d expected 0 0 0", ldata, rdata, got_q.size() - g0);
        end
        l2 = DW'($urandom); r2 = DW'($urandom);
        slots.delete();
        add_slot(1'b0, DW, DW'($urandom)); add_slot(1'b1, DW, DW'($urandom));
        add_slot(1'b0, DW, l2);            add_slot(1'b1, DW, r2);
        send_stream(1'b1);
        got = (g0 < got_q.size()) ? got_q[g0] : 'x;
        ntests++;
        if (got !== {l2, r2} || got_q.size() - g0 != 1) begin
            nfail++; $display("FAIL rstmid_first_pair: got %h (%0d pairs) expected %h (1 pair)", got, got_q.size() - g0, {l2, r2});
        end
        ntests++;
        if (err_seen != e0) begin nfail++; $display("FAIL rstmid_frame_err: got %0d expected 0", err_seen - e0); end
    endtask

    task automatic test_enable();
        logic [DW-1:0]   l1, r1, l3, r3;
        logic [2*DW-1:0] got;
        l1 = DW'($urandom); r1 = DW'($urandom); l3 = DW'($urandom); r3 = DW'($urandom);
        start_stream();
        add_slot(1'b0, DW, l1); add_slot(1'b1, DW, r1);
        send_stream(1'b1);
        en = 1'b0;
        slots.delete();
        add_slot(1'b0, DW, DW'($urandom)); add_slot(1'b1, DW, DW'($urandom));
        send_stream(1'b0);
        ntests++;
        if (got_q.size() - g0 != 1 || ldata !== l1 || rdata !== r1) begin
            nfail++; $display("FAIL enable_hold: got l=%h r=%h pairs %0d expected l=%h r=%h pairs 1", ldata, rdata, got_q.size() - g0, l1, r1);
        end
        en = 1'b1;
        slots.delete();
        add_slot(1'b0, DW, l3); add_slot(1'b1, DW, r3);
        send_stream(1'b1);
        got = (g0 + 1 < got_q.size()) ? got_q[g0 + 1] : 'x;
        ntests++;
        if (got !== {l3, r3} || got_q.size() - g0 != 2) begin
            nfail++; $display("FAIL enable_resume: got %h (%0d pairs) expected %h (2 pairs)", got, got_q.size() - g0, {l3, r3});
        end
        ntests++;
        if (err_seen != e0 || clash + wide + bad_lat != k0) begin
            nfail++; $display("FAIL enable_err_timing: got errs %0d anomalies %0d expected 0 0", err_seen - e0, clash + wide + bad_lat - k0);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_boundary();
        test_slot32();
        test_short_slot();
        test_random();
        test_reset_mid();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
